// File: rtl/kamacore_hazard_controller.sv
// kamacore_hazard_controller: stall/flush controller for the five-stage kamacore
// pipeline. Resolves data-memory waits, taken branches, load-use dependencies
// and fetch waits with a fixed priority. It also keeps a sticky data-memory
// timeout flag and a saturating count of IF stall cycles for debug.
module kamacore_hazard_controller #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned WAIT_CNT_WIDTH = 8,
   parameter int unsigned CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
   input  logic                      id_use_rs1,
   input  logic                      id_use_rs2,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   input  logic                      ex_control_memory_read,
   input  logic                      ex_branch_taken,
   input  logic                      mem_access,
   input  logic                      dmem_ready,
   input  logic                      imem_ready,
   output logic                      hold_if,
   output logic                      hold_id,
   output logic                      hold_ex,
   output logic                      hold_mem,
   output logic                      flush_id,
   output logic                      flush_ex,
   output logic                      mem_timeout,
   output logic [CNT_WIDTH-1:0]      stall_count
);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
   logic                      timeout_q, timeout_d;
   logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;

   logic        mem_wait;
   logic        rs1_hit;
   logic        rs2_hit;
   logic        load_use;
   logic [31:0] wait_elapsed;

   assign mem_wait = mem_access & ~dmem_ready;
   assign rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
   assign rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
   // x0 is hardwired to zero, so a load targeting it never creates a dependency
   assign load_use = ex_control_memory_read & (ex_rd != '0) & (rs1_hit | rs2_hit);

   // Hazard priority: memory wait, branch, load-use, fetch wait
   always_comb begin
      hold_if  = 1'b0;
      hold_id  = 1'b0;
      hold_ex  = 1'b0;
      hold_mem = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      if (mem_wait) begin
         hold_if  = 1'b1;
         hold_id  = 1'b1;
         hold_ex  = 1'b1;
         hold_mem = 1'b1;
      end else if (ex_branch_taken) begin
         flush_id = 1'b1;
         flush_ex = 1'b1;
      end else if (load_use) begin
         hold_if  = 1'b1;
         hold_id  = 1'b1;
         flush_ex = 1'b1;
      end else if (!imem_ready) begin
         hold_if  = 1'b1;
         flush_id = 1'b1;
      end
   end

   // wait_cnt is cleared on entry to MEM_WAIT, so the number of consecutive
   // wait cycles including the current one is 1 in RUN and wait_cnt+2 in MEM_WAIT
   always_comb begin
      if (state_q == MEM_WAIT) begin
         wait_elapsed = 32'(wait_cnt_q) + 32'd2;
      end else begin
         wait_elapsed = 32'd1;
      end
   end

   // Memory-wait FSM next state, wait counter and sticky timeout
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      case (state_q)
         RUN: begin
            if (mem_wait) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (dmem_ready || !mem_access) begin
               state_d = RUN;
            end else if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
      if (mem_wait && (wait_elapsed >= TIMEOUT_CYCLES)) begin
         timeout_d = 1'b1;
      end
   end

   // Saturating count of cycles where the front end is held
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (hold_if && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_kamacore_hazard_controller.sv
// Directed self-checking bench for kamacore_hazard_controller.
module tb_kamacore_hazard_controller;

   localparam int unsigned RAW = 5;
   localparam int unsigned CW  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [RAW-1:0] id_rs1, id_rs2, ex_rd;
   logic           id_use_rs1, id_use_rs2;
   logic           ex_control_memory_read, ex_branch_taken;
   logic           mem_access, dmem_ready, imem_ready;
   logic           hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex;
   logic           mem_timeout;
   logic [CW-1:0]  stall_count;
   logic [5:0]     outs;

   int vectors     = 0;
   int miscompares = 0;

   kamacore_hazard_controller #(
      .REG_ADDR_WIDTH(RAW),
      .TIMEOUT_CYCLES(4),
      .WAIT_CNT_WIDTH(8),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .id_rs1                (id_rs1),
      .id_rs2                (id_rs2),
      .id_use_rs1            (id_use_rs1),
      .id_use_rs2            (id_use_rs2),
      .ex_rd                 (ex_rd),
      .ex_control_memory_read(ex_control_memory_read),
      .ex_branch_taken       (ex_branch_taken),
      .mem_access            (mem_access),
      .dmem_ready            (dmem_ready),
      .imem_ready            (imem_ready),
      .hold_if               (hold_if),
      .hold_id               (hold_id),
      .hold_ex               (hold_ex),
      .hold_mem              (hold_mem),
      .flush_id              (flush_id),
      .flush_ex              (flush_ex),
      .mem_timeout           (mem_timeout),
      .stall_count           (stall_count)
   );

   // {hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex}
   assign outs = {hold_if, hold_id, hold_ex, hold_mem, flush_id, flush_ex};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next active edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_control_memory_read = 1'b0; ex_branch_taken = 1'b0;
      mem_access = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
   endtask

   // Short asynchronous reset pulse placed between clock edges
   task automatic pulse_rst();
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #12;
      chk("reset_outs", 32'(outs), 32'h00);
      chk("reset_stall", 32'(stall_count), 32'd0);
      chk("reset_timeout", 32'(mem_timeout), 32'd0);
      rst = 1'b0;
      cyc();

      // Load-use through rs1
      ex_control_memory_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      #1 chk("lu_rs1_outs", 32'(outs), 32'b110001);
      cyc();
      chk("lu_rs1_stall", 32'(stall_count), 32'd1);
      ex_control_memory_read = 1'b0;
      #1 chk("lu_cleared_outs", 32'(outs), 32'h00);
      // Load-use through rs2
      ex_control_memory_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
      id_use_rs1 = 1'b0;
      #1 chk("lu_rs2_outs", 32'(outs), 32'b110001);
      cyc();
      chk("lu_rs2_stall", 32'(stall_count), 32'd2);
      // Matching register but not used
      id_use_rs2 = 1'b0; id_rs1 = 5'd7; id_rs2 = 5'd3; id_use_rs1 = 1'b0;
      #1 chk("lu_unused_outs", 32'(outs), 32'h00);
      // x0 never hazards
      ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      #1 chk("lu_x0_outs", 32'(outs), 32'h00);
      cyc();
      chk("lu_x0_stall", 32'(stall_count), 32'd2);

      // Three-cycle data-memory wait
      idle_inputs();
      pulse_rst();
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         #1 chk($sformatf("mw_outs_%0d", k), 32'(outs), 32'b111100);
         cyc();
         chk($sformatf("mw_state_%0d", k), 32'(dut.state_q), 32'd1);
      end
      dmem_ready = 1'b1;
      #1 chk("mw_done_outs", 32'(outs), 32'h00);
      cyc();
      chk("mw_state_run", 32'(dut.state_q), 32'd0);
      chk("mw_stall", 32'(stall_count), 32'd3);
      chk("mw_timeout", 32'(mem_timeout), 32'd0);

      // Branch held across a two-cycle wait, with a load-use also present
      idle_inputs();
      pulse_rst();
      mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
      ex_control_memory_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
      for (int k = 1; k <= 2; k++) begin
         #1 chk($sformatf("bw_outs_%0d", k), 32'(outs), 32'b111100);
         cyc();
      end
      dmem_ready = 1'b1;
      #1 chk("bw_flush_outs", 32'(outs), 32'b000011);
      cyc();
      chk("bw_stall", 32'(stall_count), 32'd2);

      // Timeout after four consecutive wait cycles
      idle_inputs();
      pulse_rst();
      mem_access = 1'b1; dmem_ready = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         #1 chk($sformatf("to_outs_%0d", k), 32'(outs), 32'b111100);
         cyc();
         chk($sformatf("to_flag_%0d", k), 32'(mem_timeout), (k >= 4) ? 32'd1 : 32'd0);
      end
      chk("to_stall", 32'(stall_count), 32'd10);
      dmem_ready = 1'b1;
      cyc();
      chk("to_sticky_ready", 32'(mem_timeout), 32'd1);
      mem_access = 1'b0;
      cyc();
      chk("to_sticky_idle", 32'(mem_timeout), 32'd1);
      rst = 1'b1;
      #1 chk("to_cleared_by_rst", 32'(mem_timeout), 32'd0);
      rst = 1'b0;
      cyc();

      // Priority against fetch wait
      idle_inputs();
      imem_ready = 1'b0;
      ex_control_memory_read = 1'b1; ex_rd = 5'd4; id_rs2 = 5'd4; id_use_rs2 = 1'b1;
      #1 chk("pr_lu_over_fetch", 32'(outs), 32'b110001);
      ex_control_memory_read = 1'b0;
      #1 chk("pr_fetch_only", 32'(outs), 32'b100010);
      ex_branch_taken = 1'b1;
      #1 chk("pr_branch_over_fetch", 32'(outs), 32'b000011);
      mem_access = 1'b1; dmem_ready = 1'b0;
      #1 chk("pr_mem_over_all", 32'(outs), 32'b111100);

      // Stall counter saturation from fetch waits
      idle_inputs();
      pulse_rst();
      imem_ready = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         if (k == 14) chk("sat_14", 32'(stall_count), 32'd14);
         if (k == 15) chk("sat_15", 32'(stall_count), 32'd15);
      end
      chk("sat_20", 32'(stall_count), 32'd15);

      // Asynchronous reset in the middle of a memory wait
      idle_inputs();
      pulse_rst();
      mem_access = 1'b1; dmem_ready = 1'b0;
      cyc(); cyc(); cyc();
      chk("ar_pre_state", 32'(dut.state_q), 32'd1);
      chk("ar_pre_stall", 32'(stall_count), 32'd3);
      #1 rst = 1'b1;
      #1;
      chk("ar_stall", 32'(stall_count), 32'd0);
      chk("ar_state", 32'(dut.state_q), 32'd0);
      chk("ar_outs_follow_inputs", 32'(outs), 32'b111100);
      rst = 1'b0;
      idle_inputs();
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
